inst_fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF_ID stage register.
- Generates sequential ROM addresses and issues pipelined requests to an instruction ROM with variable latency.
- Buffers the returned words in an in-order queue and presents {pc, inst} to the decode side with a valid/ready handshake.
- Supports a one-cycle redirect that flushes all queued and in-flight fetches.

---
 rtl/inst_fetch_queue.sv | 139 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: sequential ROM request issue, in-order response queue, redirect flush.
// Optional FETCH_STATS_EN macro adds a saturating count of discarded ROM responses (o_flushDropCount).
module inst_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_romEnable,
    output logic [ADDR_W-1:0] o_romAddr,
    input  logic              i_romValid,
    input  logic [INST_W-1:0] i_romInst,
    output logic              o_instValid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [INST_W-1:0] o_inst,
    input  logic              i_instReady,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirectPc
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       o_flushDropCount
`endif
);

    localparam int                PW         = $clog2(DEPTH);
    localparam int                CW         = PW + 1;
    localparam logic [CW:0]       CREDIT_MAX = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc_p0;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     occ_p1;

    logic [ADDR_W-1:0] pcf_mem [DEPTH];
    logic [PW-1:0]     pcf_wr;
    logic [PW-1:0]     pcf_rd;

    logic [ADDR_W-1:0] q_pc_p1   [DEPTH];
    logic [INST_W-1:0] q_inst_p1 [DEPTH];
    logic [PW-1:0]     q_wr;
    logic [PW-1:0]     q_rd;

    logic [CW:0]       credit_used;
    logic              issue;
    logic              resp_keep;
    logic              resp_drop;
    logic              pop;
    logic              vld_p1;

    // Requests in flight plus words already queued may never exceed DEPTH, so every response has a slot.
    always_comb begin
        credit_used = {1'b0, occ_p1} + {1'b0, inflight};
        issue       = rst & ~i_redirect & (credit_used < CREDIT_MAX);
        resp_drop   = i_romValid & (drop_cnt != '0);
        resp_keep   = i_romValid & ~i_redirect & (drop_cnt == '0);
        pop         = vld_p1 & i_instReady & ~i_redirect;
    end

    // ---- p0: issue stage (fetch PC, credit and drop accounting) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_p0 <= RESET_PC;
            inflight    <= '0;
            drop_cnt    <= '0;
            occ_p1      <= '0;
            pcf_wr      <= '0;
            pcf_rd      <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(i_romValid);
            if (i_redirect) begin
                // Everything still outstanding after this cycle belongs to the old stream.
                fetch_pc_p0 <= i_redirectPc;
                drop_cnt    <= inflight - CW'(i_romValid);
                occ_p1      <= '0;
                pcf_wr      <= '0;
                pcf_rd      <= '0;
                q_wr        <= '0;
                q_rd        <= '0;
            end else begin
                if (issue) begin
                    fetch_pc_p0 <= fetch_pc_p0 + PC_STEP;
                    pcf_wr      <= pcf_wr + PW'(1);
                end
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (resp_keep) begin
                    pcf_rd <= pcf_rd + PW'(1);
                    q_wr   <= q_wr + PW'(1);
                end
                if (pop) begin
                    q_rd <= q_rd + PW'(1);
                end
                occ_p1 <= occ_p1 + CW'(resp_keep) - CW'(pop);
            end
        end
    end

    // ---- p1: response stage (PC pairing and queue storage) ----
    always_ff @(posedge clk) begin
        if (issue) begin
            pcf_mem[pcf_wr] <= fetch_pc_p0;
        end
        if (resp_keep) begin
            q_pc_p1[q_wr]   <= pcf_mem[pcf_rd];
            q_inst_p1[q_wr] <= i_romInst;
        end
    end

    assign vld_p1      = (occ_p1 != '0);
    assign o_romEnable = issue;
    assign o_romAddr   = fetch_pc_p0;
    assign o_instValid = vld_p1;
    assign o_pc        = vld_p1 ? q_pc_p1[q_rd]   : '0;
    assign o_inst      = vld_p1 ? q_inst_p1[q_rd] : '0;

`ifdef FETCH_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic resp_discard;
    assign resp_discard = i_romValid & (i_redirect | (drop_cnt != '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_flushDropCount <= '0;
        end else if (resp_discard) begin
            o_flushDropCount <= sat_inc16(o_flushDropCount);
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue with a variable-latency ROM model.
`timescale 1ns/1ps
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_romEnable;
    logic [31:0] o_romAddr;
    logic        i_romValid;
    logic [31:0] i_romInst;
    logic        o_instValid;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        i_instReady;
    logic        i_redirect;
    logic [31:0] i_redirectPc;
`ifdef FETCH_STATS_EN
    logic [15:0] flush_drop_count;
`endif

    always #5 clk = ~clk;

    inst_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .o_romEnable (o_romEnable),
        .o_romAddr   (o_romAddr),
        .i_romValid  (i_romValid),
        .i_romInst   (i_romInst),
        .o_instValid (o_instValid),
        .o_pc        (o_pc),
        .o_inst      (o_inst),
        .i_instReady (i_instReady),
        .i_redirect  (i_redirect),
        .i_redirectPc(i_redirectPc)
`ifdef FETCH_STATS_EN
        ,
        .o_flushDropCount(flush_drop_count)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } rom_req_t;

    rom_req_t    rom_req[$];
    logic [31:0] sb_pc[$];
    logic [31:0] pop_log[$];
    logic [31:0] model_pc;
    logic [31:0] exp_pc;
    int          cyc;
    int          lat;
    int          issue_cnt;
    int          pop_cnt;
    int          live_out;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        rst          = 1'b0;
        i_redirect   = 1'b0;
        i_redirectPc = '0;
        i_instReady  = 1'b0;
        repeat (2) tick();
        lat = l;
        rst = 1'b1;
    endtask

    // ROM: answers each request exactly lat cycles later, in order, including stale ones.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst && rom_req.size() != 0 && rom_req[0].due <= cyc) begin
            i_romValid = 1'b1;
            i_romInst  = rom_word(rom_req[0].addr);
            void'(rom_req.pop_front());
        end else begin
            i_romValid = 1'b0;
            i_romInst  = '0;
        end
    end

    // Scoreboard: expected fetch PCs are queued at issue and retired at each accepted pop.
    always @(negedge clk) begin
        if (!rst) begin
            rom_req.delete();
            sb_pc.delete();
            pop_log.delete();
            model_pc  = 32'h0;
            issue_cnt = 0;
            pop_cnt   = 0;
        end else begin
            if (i_redirect) begin
                check("redir_no_issue", o_romEnable, 1'b0);
                model_pc = i_redirectPc;
                sb_pc.delete();
                foreach (rom_req[i]) rom_req[i].live = 1'b0;
            end
            if (o_romEnable) begin
                check("issue_addr", o_romAddr, model_pc);
                rom_req.push_back('{addr: o_romAddr, due: cyc + lat, live: 1'b1});
                sb_pc.push_back(model_pc);
                model_pc = model_pc + 32'd4;
                issue_cnt++;
            end
            if (o_instValid && i_instReady && !i_redirect) begin
                check("pop_avail", sb_pc.size() != 0, 1'b1);
                if (sb_pc.size() != 0) begin
                    exp_pc = sb_pc.pop_front();
                    check("pop_pc", o_pc, exp_pc);
                    check("pop_inst", o_inst, rom_word(exp_pc));
                end
                pop_log.push_back(o_pc);
                pop_cnt++;
            end
            live_out = 0;
            foreach (rom_req[i]) if (rom_req[i].live) live_out++;
            check("credit_inv", (rom_req.size() + sb_pc.size() - live_out) <= DEPTH, 1'b1);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        cyc          = 0;
        lat          = 1;
        rst          = 1'b1;
        i_romValid   = 1'b0;
        i_romInst    = '0;
        i_instReady  = 1'b0;
        i_redirect   = 1'b0;
        i_redirectPc = '0;
        #2 rst = 1'b0;
        tick();
        check("rst_en", o_romEnable, 1'b0);
        check("rst_valid", o_instValid, 1'b0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_inst", o_inst, 32'h0);
        check("rst_addr", o_romAddr, 32'h0);
`ifdef FETCH_STATS_EN
        check("rst_drops", flush_drop_count, 16'h0);
`endif

        // Latency 1, consumer always ready: one instruction per cycle after two cycles.
        do_reset(1);
        i_instReady = 1'b1;
        @(negedge clk);
        check("t1_en", o_romEnable, 1'b1);
        check("t1_addr0", o_romAddr, 32'h0);
        check("t1_empty0", o_instValid, 1'b0);
        @(negedge clk);
        check("t1_empty1", o_instValid, 1'b0);
        @(negedge clk);
        check("t1_valid2", o_instValid, 1'b1);
        check("t1_pc2", o_pc, 32'h0);
        repeat (17) @(negedge clk);
        tick();
        i_instReady = 1'b0;
        check("t1_pops", pop_cnt, 18);

        // Latency 3, consumer stalled: credits stop issue after four requests.
        do_reset(3);
        repeat (12) @(negedge clk);
        check("t2_issues", issue_cnt, 4);
        check("t2_en_off", o_romEnable, 1'b0);
        check("t2_valid", o_instValid, 1'b1);
        check("t2_head", o_pc, 32'h0);
        tick();
        i_instReady = 1'b1;
        repeat (4) tick();
        i_instReady = 1'b0;
        check("t2_pops", pop_cnt, 4);
        check("t2_log_n", pop_log.size(), 4);
        if (pop_log.size() >= 4) check("t2_pop3", pop_log[3], 32'd12);
        repeat (6) @(negedge clk);
        check("t2_resume_head", o_pc, 32'd16);

        // Redirect with two queued and two in flight.
        do_reset(3);
        repeat (5) tick();
        i_redirect   = 1'b1;
        i_redirectPc = 32'h100;
        @(negedge clk);
        check("t3_no_issue", o_romEnable, 1'b0);
        tick();
        i_redirect = 1'b0;
        @(negedge clk);
        check("t3_flushed", o_instValid, 1'b0);
        check("t3_reissue_en", o_romEnable, 1'b1);
        check("t3_reissue_addr", o_romAddr, 32'h100);
        for (int i = 0; i < 20 && !o_instValid; i++) @(negedge clk);
        check("t3_valid", o_instValid, 1'b1);
        check("t3_pc", o_pc, 32'h100);
`ifdef FETCH_STATS_EN
        check("t3_drops", flush_drop_count, 16'd2);
`endif

        // Redirect near the top of the address space: PC wraps to zero.
        do_reset(2);
        i_instReady = 1'b1;
        repeat (3) tick();
        i_redirect   = 1'b1;
        i_redirectPc = 32'hFFFF_FFF8;
        pop_log.delete();
        tick();
        i_redirect = 1'b0;
        repeat (10) tick();
        check("t4_count", pop_log.size() >= 3, 1'b1);
        if (pop_log.size() >= 3) begin
            check("t4_pc0", pop_log[0], 32'hFFFF_FFF8);
            check("t4_pc1", pop_log[1], 32'hFFFF_FFFC);
            check("t4_pc2", pop_log[2], 32'h0);
        end

        // Redirect colliding with a ROM response and a pop in the same cycle.
        do_reset(2);
        i_instReady = 1'b1;
        repeat (6) tick();
        i_redirect   = 1'b1;
        i_redirectPc = 32'h2000;
        pop_log.delete();
        @(negedge clk);
        check("t5_valid_before", o_instValid, 1'b1);
        check("t5_no_issue", o_romEnable, 1'b0);
        tick();
        i_redirect = 1'b0;
        @(negedge clk);
        check("t5_flushed", o_instValid, 1'b0);
        check("t5_issue_en", o_romEnable, 1'b1);
        check("t5_issue_addr", o_romAddr, 32'h2000);
        repeat (8) tick();
        check("t5_count", pop_log.size() >= 1, 1'b1);
        if (pop_log.size() >= 1) check("t5_first_pc", pop_log[0], 32'h2000);

        // Asynchronous reset in the middle of a stream with three words queued.
        do_reset(1);
        repeat (4) tick();
        #1;
        check("t6_valid_pre", o_instValid, 1'b1);
        rst = 1'b0;
        #1;
        check("t6_async_valid", o_instValid, 1'b0);
        check("t6_async_en", o_romEnable, 1'b0);
        check("t6_async_pc", o_pc, 32'h0);
        repeat (2) tick();
        rst         = 1'b1;
        i_instReady = 1'b1;
        @(negedge clk);
        check("t6_restart_en", o_romEnable, 1'b1);
        check("t6_restart_addr", o_romAddr, 32'h0);
        repeat (8) tick();
        check("t6_count", pop_log.size() >= 1, 1'b1);
        if (pop_log.size() >= 1) check("t6_first_pc", pop_log[0], 32'h0);

        i_instReady = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
